// File: rtl/nes_axi_regbank.sv
`default_nettype none
// ============================================================================
// Module      : nes_axi_regbank
// Description : AXI4-Lite slave register bank for the NES core. Holds
//               NUM_CTRL read/write control words, NUM_STAT read-only status
//               words, a sticky write-1-to-clear EVENT register and an
//               IRQ_EN register that together drive a level interrupt.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module nes_axi_regbank #(
    parameter int          DATA_WIDTH = 32,   // fixed at 32
    parameter int          ADDR_WIDTH = 6,
    parameter int          NUM_CTRL   = 4,
    parameter int          NUM_STAT   = 4,
    parameter logic [31:0] CTRL_RESET = 32'h0
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESET,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                   S_AXI_AWPROT,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                   S_AXI_ARPROT,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic [NUM_CTRL*32-1:0]       ctrl_out,
    output logic [NUM_CTRL-1:0]          ctrl_wr,
    input  logic [NUM_STAT*32-1:0]       stat_in,
    input  logic [31:0]                  event_in,
    output logic                         irq
);

    localparam int          c_IDX_W       = ADDR_WIDTH - 2;
    localparam int          c_IDX_STAT    = NUM_CTRL;
    localparam int          c_IDX_EVENT   = NUM_CTRL + NUM_STAT;
    localparam int          c_IDX_IRQEN   = c_IDX_EVENT + 1;
    localparam int          c_NUM_WORDS   = c_IDX_IRQEN + 1;
    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] f_strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    logic rst;
    assign rst = S_AXI_ARESET;

    // Write-side state
    logic               r_aw_held;
    logic [c_IDX_W-1:0] r_aw_idx;
    logic               r_w_held;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_bvalid;
    logic [1:0]         r_bresp;

    // Read-side state
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;

    // Register file
    logic [31:0]        r_ctrl    [NUM_CTRL];
    logic               r_ctrl_wr [NUM_CTRL];
    logic [31:0]        r_event;
    logic [31:0]        r_irq_en;
    logic               r_irq;

    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_ar_hs;
    logic               w_commit;
    logic [31:0]        w_wr_idx;
    logic [31:0]        w_rd_idx;
    logic [31:0]        w_wmask;
    logic [31:0]        w_clr_mask;
    logic [31:0]        w_rd_data;
    logic [1:0]         w_rd_resp;
    logic               w_unused;

    // Ready signals are held low through reset so no handshake can occur.
    assign S_AXI_AWREADY = !rst && !r_aw_held && !r_bvalid;
    assign S_AXI_WREADY  = !rst && !r_w_held  && !r_bvalid;
    assign S_AXI_ARREADY = !rst && !r_rvalid;

    assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;

    // A write commits only from the held address/data pair, giving a fixed
    // one-cycle gap between the last handshake and BVALID.
    assign w_commit = r_aw_held && r_w_held;
    assign w_wr_idx = {{(32-c_IDX_W){1'b0}}, r_aw_idx};
    assign w_rd_idx = {{(32-c_IDX_W){1'b0}}, S_AXI_ARADDR[ADDR_WIDTH-1:2]};
    assign w_wmask  = f_strb_mask(r_wstrb);

    assign w_clr_mask = (w_commit && (w_wr_idx == c_IDX_EVENT)) ? (r_wdata & w_wmask) : 32'h0;

    // Protection bits and byte offsets carry no meaning for this block.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Capture write address/data on their own handshakes and issue the response.
    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= (w_wr_idx < c_NUM_WORDS) ? c_RESP_OKAY : c_RESP_SLVERR;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl
            // Byte-merge a committed write into control word i and pulse its strobe.
            always_ff @(posedge S_AXI_ACLK) begin
                if (rst) begin
                    r_ctrl[i]    <= CTRL_RESET;
                    r_ctrl_wr[i] <= 1'b0;
                end else begin
                    r_ctrl_wr[i] <= w_commit && (w_wr_idx == i);
                    if (w_commit && (w_wr_idx == i)) begin
                        r_ctrl[i] <= (r_ctrl[i] & ~w_wmask) | (r_wdata & w_wmask);
                    end
                end
            end
            assign ctrl_out[32*i +: 32] = r_ctrl[i];
            assign ctrl_wr[i]           = r_ctrl_wr[i];
        end
    endgenerate

    // Sticky events (set beats clear), interrupt enables and the registered IRQ.
    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            r_event  <= 32'h0;
            r_irq_en <= 32'h0;
            r_irq    <= 1'b0;
        end else begin
            r_event <= (r_event & ~w_clr_mask) | event_in;
            if (w_commit && (w_wr_idx == c_IDX_IRQEN)) begin
                r_irq_en <= (r_irq_en & ~w_wmask) | (r_wdata & w_wmask);
            end
            r_irq <= |(r_event & r_irq_en);
        end
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        w_rd_data = 32'h0;
        w_rd_resp = c_RESP_OKAY;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (w_rd_idx == k) w_rd_data = r_ctrl[k];
        end
        for (int k = 0; k < NUM_STAT; k++) begin
            if (w_rd_idx == (c_IDX_STAT + k)) w_rd_data = stat_in[32*k +: 32];
        end
        if (w_rd_idx == c_IDX_EVENT) w_rd_data = r_event;
        if (w_rd_idx == c_IDX_IRQEN) w_rd_data = r_irq_en;
        if (w_rd_idx >= c_NUM_WORDS) w_rd_resp = c_RESP_SLVERR;
    end

    // Register read data at address acceptance and hold it until RREADY.
    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
            r_rresp  <= c_RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;
    assign irq          = r_irq;

endmodule
`default_nettype wire
